// File: rtl/dma_packer_pkg.sv
// dma_packer shared constants and bundle types.
// The PCIe DMA writer uses the same beat, burst and address geometry.
package dma_packer_pkg;

  localparam int DMA_BEAT_W      = 128;
  localparam int DMA_BURST_BYTES = 128;
  localparam int DMA_AW          = 23;
  localparam int DMA_BURST_SH    = 7;
  localparam int DMA_WORD_W      = 32;
  localparam int DMA_LANES       = DMA_BEAT_W / DMA_WORD_W;

  typedef struct packed {
    logic                  last;
    logic [DMA_BEAT_W-1:0] data;
  } dma_beat_t;

endpackage

// File: rtl/dma_lane_packer.sv
// 32-to-128 lane assembler: fills lanes low to high, flushes on frame end.
// beat_v/beat describe the beat completed by the current cycle's inputs.
module dma_lane_packer
  import dma_packer_pkg::*;
(
  input  logic                  c,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  acc,
  input  logic                  flush,
  input  logic [DMA_WORD_W-1:0] word,
  output logic                  beat_v,
  output dma_beat_t             beat
);

  logic [1:0]            lane;
  logic [1:0]            lane_eff;
  logic [DMA_BEAT_W-1:0] acc_q;
  logic [DMA_BEAT_W-1:0] acc_eff;
  logic [DMA_BEAT_W-1:0] merged;

  // Frame start discards any partial beat before the word lands.
  always_comb begin
    lane_eff = clr ? '0 : lane;
    acc_eff  = clr ? '0 : acc_q;
    merged   = acc_eff;
    if (acc) merged[{lane_eff, 5'b0} +: DMA_WORD_W] = word;
    beat_v    = (acc && lane_eff == 2'(DMA_LANES - 1)) || flush;
    beat.last = flush;
    beat.data = merged;
  end

  // Clearing after each beat gives zero upper lanes on a flush.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      lane  <= '0;
      acc_q <= '0;
    end else if (beat_v) begin
      lane  <= '0;
      acc_q <= '0;
    end else begin
      lane  <= acc ? lane_eff + 2'd1 : lane_eff;
      acc_q <= merged;
    end
  end

endmodule

// File: rtl/dma_packer.sv
// Packs 32-bit camera words into 128-bit beats and bursts for the DMA writer.
// Holds burst counter, address generator, drop counter and frame control.
module dma_packer
  import dma_packer_pkg::*;
#(
  parameter int BURST_BEATS = 8,
  parameter int AW          = DMA_AW
) (
  input  logic                  c,
  input  logic                  rst_n,
  input  logic [DMA_WORD_W-1:0] pd,
  input  logic                  pdv,
  input  logic                  pfs,
  input  logic                  pfe,
  input  logic [AW-1:0]         buf_base,
  input  logic [15:0]           buf_bursts,
  output logic [DMA_BEAT_W-1:0] d,
  output logic                  dv,
  output logic                  de,
  output logic [AW-1:0]         daddr,
  input  logic                  ready,
  output logic                  frame_done,
  output logic [15:0]           drop_cnt,
  output logic                  wrapped
);

  logic          ready_q;
  logic          fs;
  logic          fe;
  logic          acc;
  logic [AW-1:0] base_q;
  logic [AW-1:0] base_eff;
  logic [15:0]   bursts_q;
  logic [15:0]   bursts_eff;
  logic [15:0]   off;
  logic [15:0]   off_eff;
  logic [4:0]    beat_cnt;
  logic [4:0]    beat_eff;
  logic          beat_v;
  dma_beat_t     beat;
  logic          last;
  logic          wrap_now;
  logic          wrap_evt;
  logic [AW-1:0] addr_n;
  logic [DMA_BURST_SH+15:0] off_bytes;

  // Frame control acts even when the word itself is dropped.
  assign fs  = pdv & pfs;
  assign fe  = pdv & pfe;
  assign acc = pdv & ready_q;

  dma_lane_packer u_lane (
    .c      (c),
    .rst_n  (rst_n),
    .clr    (fs),
    .acc    (acc),
    .flush  (fe),
    .word   (pd),
    .beat_v (beat_v),
    .beat   (beat)
  );

  always_comb begin
    base_eff   = fs ? buf_base : base_q;
    bursts_eff = fs ? buf_bursts : bursts_q;
    off_eff    = fs ? '0 : off;
    beat_eff   = fs ? '0 : beat_cnt;
    off_bytes  = {off_eff, {DMA_BURST_SH{1'b0}}};
    addr_n     = base_eff + AW'(off_bytes);
    last       = beat_v &
                 (beat.last | (beat_eff == 5'(BURST_BEATS - 1)));
    wrap_now   = last & (off_eff == bursts_eff);
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      base_q   <= '0;
      bursts_q <= '0;
      off      <= '0;
      beat_cnt <= '0;
      wrap_evt <= 1'b0;
    end else begin
      ready_q  <= ready;
      wrap_evt <= wrap_now;
      if (fs) begin
        base_q   <= buf_base;
        bursts_q <= buf_bursts;
      end
      if (last) beat_cnt <= '0;
      else if (beat_v) beat_cnt <= beat_eff + 5'd1;
      else beat_cnt <= beat_eff;
      if (last) off <= wrap_now ? '0 : off_eff + 16'd1;
      else off <= off_eff;
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      d          <= '0;
      dv         <= 1'b0;
      de         <= 1'b0;
      daddr      <= '0;
      frame_done <= 1'b0;
    end else begin
      dv         <= beat_v;
      de         <= last;
      frame_done <= beat_v & beat.last;
      if (beat_v) begin
        d     <= beat.data;
        daddr <= addr_n;
      end
    end
  end

  // wrapped trails the wrapping de by one cycle; frame start wins.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      wrapped  <= 1'b0;
    end else begin
      if (pdv && !ready_q && !(&drop_cnt)) drop_cnt <= drop_cnt + 16'd1;
      if (fs) wrapped <= 1'b0;
      else if (wrap_evt) wrapped <= 1'b1;
    end
  end

endmodule
